// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encoding and operand-signedness decode.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    ADJUST = 2'd2,
    DONE   = 2'd3
  } state_t;

  // rs1 is treated as two's complement
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as two's complement
  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // upper half of funct3 space is the divide family
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] operandA;
  logic [XLEN-1:0] operandB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, kill, op, operandA, operandB,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, op, operandA, operandB,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration, purely combinational.
// Multiply: {hi,lo} holds partial product / remaining multiplier; add the
// multiplicand into hi when lo[0] is set, then shift the pair right.
// Divide: hi is the partial remainder, lo shifts the dividend out of its MSB
// while quotient bits shift in at the LSB (restoring trial subtract).
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;

  // add-shift or trial-subtract, selected by operation family
  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_shift = {i_hi, i_lo[XLEN-1]};
    // when the trial succeeds the difference is below the divisor, so XLEN bits suffice
    w_diff  = w_shift[XLEN-1:0] - i_opnd;
    if (i_is_div) begin
      if (w_shift >= {1'b0, i_opnd}) begin
        o_hi = w_diff;
        o_lo = {i_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi = w_shift[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. Operands are converted to magnitudes at
// start, UNROLL radix-2 steps run per CALC cycle, and the sign is restored in
// ADJUST. Divide-by-zero and signed overflow bypass CALC entirely.
//
//  state  | meaning
//  IDLE   | waiting for start
//  CALC   | iterating on magnitudes, count down to 1
//  ADJUST | sign correction, result select and register
//  DONE   | one-cycle done pulse
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic            r_neg_a, r_neg_b;
  logic [XLEN-1:0] r_hi, r_lo, r_opnd, r_result;
  logic [CW-1:0]   r_count;

  logic            w_sa, w_sb, w_div_zero, w_ovf, w_special, w_accept;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_special_res, w_adj_res;
  logic [XLEN-1:0] w_quo, w_rem;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_hi_chain [UNROLL+1];
  logic [XLEN-1:0] w_lo_chain [UNROLL+1];

  // operand decode at acceptance, including the shortcut divide cases
  always_comb begin
    w_sa       = is_signed_a(bus.op) & bus.operandA[XLEN-1];
    w_sb       = is_signed_b(bus.op) & bus.operandB[XLEN-1];
    w_abs_a    = w_sa ? -bus.operandA : bus.operandA;
    w_abs_b    = w_sb ? -bus.operandB : bus.operandB;
    w_div_zero = is_div(bus.op) && (bus.operandB == '0);
    w_ovf      = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                 (bus.operandA == MIN_VAL) && (bus.operandB == '1);
    w_special  = w_div_zero || w_ovf;
    if (w_div_zero) w_special_res = bus.op[1] ? bus.operandA : '1;
    else            w_special_res = bus.op[1] ? '0 : MIN_VAL;
    w_accept   = (r_state == IDLE) && bus.start && !bus.kill;
  end

  assign w_hi_chain[0] = r_hi;
  assign w_lo_chain[0] = r_lo;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .i_is_div (is_div(r_op)),
      .i_hi     (w_hi_chain[g]),
      .i_lo     (w_lo_chain[g]),
      .i_opnd   (r_opnd),
      .o_hi     (w_hi_chain[g+1]),
      .o_lo     (w_lo_chain[g+1])
    );
  end

  // sign restoration and result selection
  always_comb begin
    w_prod = (r_neg_a ^ r_neg_b) ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_quo  = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
    w_rem  = r_neg_a ? -r_hi : r_hi;
    case (r_op)
      OP_MUL:                       w_adj_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_adj_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_adj_res = w_quo;
      default:                      w_adj_res = w_rem;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic; kill aborts any in-flight computation
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : CALC;
      CALC:    if (bus.kill) w_state_nxt = IDLE;
               else if (r_count == CW'(1)) w_state_nxt = ADJUST;
      ADJUST:  w_state_nxt = bus.kill ? IDLE : DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // datapath: load magnitudes on accept, iterate in CALC, capture result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= bus.op;
        r_neg_a <= w_sa;
        r_neg_b <= w_sb;
        r_hi    <= '0;
        r_count <= CW'(STEPS);
        r_lo    <= is_div(bus.op) ? w_abs_a : w_abs_b;
        r_opnd  <= is_div(bus.op) ? w_abs_b : w_abs_a;
        if (w_special) r_result <= w_special_res;
      end else if (r_state == CALC) begin
        r_hi    <= w_hi_chain[UNROLL];
        r_lo    <= w_lo_chain[UNROLL];
        r_count <= r_count - CW'(1);
      end
      if ((r_state == ADJUST) && !bus.kill) r_result <= w_adj_res;
    end
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = (r_state == DONE);
  assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: two units (UNROLL=1 and UNROLL=4) checked against an
// arithmetic reference model for result, latency and busy duration.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) m1 ();
  muldiv_if #(.XLEN(32)) m4 ();

  muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (.clk(clk), .rst(rst), .bus(m1));
  muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (.clk(clk), .rst(rst), .bus(m4));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int unroll);
    if (op[2] && (b == 0)) return 1;
    if (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 32 / unroll + 2;
  endfunction

  task automatic set_in(input bit u4, input logic st, input logic kl, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    if (u4) begin
      m4.start = st; m4.kill = kl; m4.op = op; m4.operandA = a; m4.operandB = b;
    end else begin
      m1.start = st; m1.kill = kl; m1.op = op; m1.operandA = a; m1.operandB = b;
    end
  endtask

  function automatic logic get_busy(input bit u4);
    return u4 ? m4.busy : m1.busy;
  endfunction

  function automatic logic get_done(input bit u4);
    return u4 ? m4.done : m1.done;
  endfunction

  function automatic logic [31:0] get_result(input bit u4);
    return u4 ? m4.result : m1.result;
  endfunction

  // Starts one operation (caller is #1 after a rising edge) and waits for done.
  // lat = cycle index of the done pulse counted from the start edge.
  task automatic run_op(input bit u4, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, output logic [31:0] res, output int lat, output int busyc,
                        output bit got, output logic done_after);
    set_in(u4, 1'b1, 1'b0, op, a, b);
    @(posedge clk); #1;
    set_in(u4, 1'b0, 1'b0, 3'($urandom), $urandom, $urandom);
    got = 1'b0; lat = 0; busyc = 0; res = '0;
    for (int k = 1; k <= 200; k++) begin
      if (poke) set_in(u4, (k == 3), 1'b0, 3'($urandom), $urandom, $urandom);
      if (get_busy(u4)) busyc++;
      if (get_done(u4)) begin
        got = 1'b1; lat = k; res = get_result(u4);
        break;
      end
      @(posedge clk); #1;
    end
    set_in(u4, 1'b0, 1'b0, 3'd0, '0, '0);
    @(posedge clk); #1;
    done_after = get_done(u4);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (m1.busy !== 1'b0 || m1.done !== 1'b0 || m1.result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_u1: busy=%b done=%b result=%h, expected 0/0/0", m1.busy, m1.done, m1.result);
    end
    n_cmp++;
    if (m4.busy !== 1'b0 || m4.done !== 1'b0 || m4.result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_u4: busy=%b done=%b result=%h, expected 0/0/0", m4.busy, m4.done, m4.result);
    end
  endtask

  task automatic test_directed();
    vec_t v[$];
    logic [31:0] res;
    int lat, busyc;
    bit got;
    logic da;
    v.push_back(mk(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34));
    v.push_back(mk(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34));
    v.push_back(mk(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34));
    v.push_back(mk(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34));
    v.push_back(mk(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34));
    v.push_back(mk(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34));
    v.push_back(mk(OP_DIVU,   32'd100,        32'd7,         32'd14,        34));
    v.push_back(mk(OP_REMU,   32'd100,        32'd7,         32'd2,         34));
    v.push_back(mk(OP_DIVU,   32'h1234,       32'd0,         32'hFFFF_FFFF, 1));
    v.push_back(mk(OP_REM,    32'h1234,       32'd0,         32'h1234,      1));
    v.push_back(mk(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1));
    v.push_back(mk(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1));
    foreach (v[i]) begin
      run_op(1'b0, v[i].op, v[i].a, v[i].b, 1'b0, res, lat, busyc, got, da);
      n_cmp++;
      if (!got) begin
        n_err++;
        $display("FAIL directed_timeout[%0d]: no done within budget, expected done at cycle %0d", i, v[i].lat);
      end
      n_cmp++;
      if (res !== v[i].exp) begin
        n_err++;
        $display("FAIL directed_result[%0d] op=%0d: got %h, expected %h", i, v[i].op, res, v[i].exp);
      end
      n_cmp++;
      if (lat !== v[i].lat || busyc !== v[i].lat) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: done at %0d busy %0d cycles, expected %0d", i, lat, busyc, v[i].lat);
      end
      n_cmp++;
      if (da !== 1'b0 || m1.busy !== 1'b0) begin
        n_err++;
        $display("FAIL directed_pulse[%0d]: done=%b busy=%b after done cycle, expected 0/0", i, da, m1.busy);
      end
    end
  endtask

  task automatic test_random(input bit u4, input int n);
    logic [2:0] op;
    logic [31:0] a, b, res, exp;
    int lat, busyc, el;
    bit got;
    logic da;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = $urandom_range(1, 15);
        4: a = $urandom_range(0, 255);
        default: ;
      endcase
      exp = ref_op(op, a, b);
      el  = ref_lat(op, a, b, u4 ? 4 : 1);
      run_op(u4, op, a, b, 1'b0, res, lat, busyc, got, da);
      n_cmp++;
      if (res !== exp || lat !== el || !got) begin
        n_err++;
        $display("FAIL random_u%0d[%0d] op=%0d a=%h b=%h: got %h at cycle %0d, expected %h at cycle %0d",
                 u4 ? 4 : 1, i, op, a, b, res, lat, exp, el);
      end
    end
  endtask

  task automatic test_unroll4();
    logic [31:0] res;
    int lat, busyc;
    bit got;
    logic da;
    run_op(1'b1, OP_DIVU, 32'hFFFF_FFFF, 32'd3, 1'b0, res, lat, busyc, got, da);
    n_cmp++;
    if (res !== 32'h5555_5555 || lat !== 10 || busyc !== 10) begin
      n_err++;
      $display("FAIL unroll4_divu: got %h at cycle %0d busy %0d, expected 55555555 at cycle 10 busy 10",
               res, lat, busyc);
    end
  endtask

  task automatic test_kill();
    logic [31:0] res, a, b;
    int lat, busyc;
    bit got, seen;
    logic da;
    run_op(1'b0, OP_DIVU, 32'd100, 32'd7, 1'b0, res, lat, busyc, got, da);
    n_cmp++;
    if (res !== 32'd14) begin
      n_err++;
      $display("FAIL kill_setup: got %h, expected 0000000e", res);
    end
    // kill in CALC, 10 cycles after the start edge
    set_in(1'b0, 1'b1, 1'b0, OP_MUL, $urandom, $urandom);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0, OP_MUL, $urandom, $urandom);
    seen = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (m1.done) seen = 1'b1;
      @(posedge clk); #1;
    end
    if (m1.done) seen = 1'b1;
    m1.kill = 1'b1;
    @(posedge clk); #1;
    m1.kill = 1'b0;
    n_cmp++;
    if (m1.busy !== 1'b0 || m1.done !== 1'b0 || seen || m1.result !== 32'd14) begin
      n_err++;
      $display("FAIL kill_calc: busy=%b done=%b seen_done=%b result=%h, expected 0/0/0/0000000e",
               m1.busy, m1.done, seen, m1.result);
    end
    // restart immediately after the kill
    a = $urandom; b = $urandom;
    run_op(1'b0, OP_MULHU, a, b, 1'b0, res, lat, busyc, got, da);
    n_cmp++;
    if (res !== ref_op(OP_MULHU, a, b) || lat !== 34) begin
      n_err++;
      $display("FAIL kill_restart: got %h at cycle %0d, expected %h at cycle 34", res, lat, ref_op(OP_MULHU, a, b));
    end
    // start together with kill in IDLE is ignored
    set_in(1'b0, 1'b1, 1'b1, OP_MUL, 32'd3, 32'd5);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0, OP_MUL, '0, '0);
    n_cmp++;
    if (m1.busy !== 1'b0) begin
      n_err++;
      $display("FAIL kill_with_start: busy=%b, expected 0", m1.busy);
    end
    // kill in ADJUST on the UNROLL=4 unit (ADJUST is cycle 9 after start)
    set_in(1'b1, 1'b1, 1'b0, OP_MUL, 32'd9, 32'd9);
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 1'b0, OP_MUL, '0, '0);
    seen = 1'b0;
    for (int k = 1; k < 9; k++) begin
      if (m4.done) seen = 1'b1;
      @(posedge clk); #1;
    end
    if (m4.done) seen = 1'b1;
    m4.kill = 1'b1;
    @(posedge clk); #1;
    m4.kill = 1'b0;
    n_cmp++;
    if (m4.busy !== 1'b0 || m4.done !== 1'b0 || seen || m4.result !== 32'h5555_5555) begin
      n_err++;
      $display("FAIL kill_adjust: busy=%b done=%b seen_done=%b result=%h, expected 0/0/0/55555555",
               m4.busy, m4.done, seen, m4.result);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [31:0] a, b, res;
    int lat, busyc;
    bit got;
    logic da;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom_range(1, 1000);
      run_op(i[0], op, a, b, 1'b1, res, lat, busyc, got, da);
      n_cmp++;
      if (res !== ref_op(op, a, b) || lat !== ref_lat(op, a, b, i[0] ? 4 : 1) || get_busy(i[0]) !== 1'b0) begin
        n_err++;
        $display("FAIL back_to_back[%0d] op=%0d: got %h at cycle %0d, expected %h at cycle %0d",
                 i, op, res, lat, ref_op(op, a, b), ref_lat(op, a, b, i[0] ? 4 : 1));
      end
    end
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 1'b1, 1'b0, OP_MUL, 32'h1234_5678, 32'h9ABC_DEF1);
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 1'b0, OP_MUL, '0, '0);
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (m4.busy !== 1'b1) begin
      n_err++;
      $display("FAIL areset_pre: busy=%b, expected 1", m4.busy);
    end
    rst = 1'b1;
    #2;
    n_cmp++;
    if (m4.busy !== 1'b0 || m4.done !== 1'b0 || m4.result !== 32'h0) begin
      n_err++;
      $display("FAIL areset_mid_calc: busy=%b done=%b result=%h, expected 0/0/0", m4.busy, m4.done, m4.result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
    set_in(1'b1, 1'b0, 1'b0, 3'd0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_directed();
    test_random(1'b0, 30);
    test_random(1'b1, 30);
    test_unroll4();
    test_kill();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
